// File: rtl/dsa_pkg.sv
// Shared types and constants for the DSA pixel engine.
// Holds the engine state enum, Q8.8 constants and the per-axis clamp helper.
package dsa_pkg;

  localparam int unsigned FRAC_BITS  = 8;
  localparam logic [15:0] ONE_Q8_8   = 16'h0100;
  localparam int unsigned ROUND_HALF = 32768;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_FETCH  = 3'd2,
    S_CAPT   = 3'd3,
    S_INTERP = 3'd4,
    S_WRITE  = 3'd5
  } pe_state_t;

  typedef struct packed {
    logic [15:0] c0;
    logic [15:0] c1;
    logic [7:0]  f;
  } axis_t;

  // Source position along one axis; clamps at the last sample and zeroes the fraction there.
  function automatic axis_t axis_calc(input logic [15:0] o, input logic [15:0] step,
                                      input int unsigned lim_m1);
    logic [31:0] xs;
    logic [23:0] pos;
    axis_t       r;
    xs  = 32'(o) * 32'(step);
    pos = xs[31:FRAC_BITS];
    if (32'(pos) >= lim_m1) begin
      r.c0 = 16'(lim_m1);
      r.c1 = 16'(lim_m1);
      r.f  = 8'd0;
    end else begin
      r.c0 = 16'(pos);
      r.c1 = 16'(pos) + 16'd1;
      r.f  = xs[FRAC_BITS-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dsa_bilinear_mac.sv
// Combinational bilinear blend of four 8-bit samples with Q0.8 fractions.
// Rounds to nearest and saturates to 8 bits.
module dsa_bilinear_mac
  import dsa_pkg::*;
(
  input  logic [7:0] fx,
  input  logic [7:0] fy,
  input  logic [7:0] i00,
  input  logic [7:0] i10,
  input  logic [7:0] i01,
  input  logic [7:0] i11,
  output logic [7:0] pix_c
);

  localparam int unsigned WT_W  = 9;
  localparam int unsigned PW_W  = 17;
  localparam int unsigned ACC_W = 25;

  logic [WT_W-1:0]  wx0, wx1, wy0, wy1;
  logic [PW_W-1:0]  w00, w10, w01, w11;
  logic [ACC_W-1:0] sum, rnd;
  logic [8:0]       res;

  always_comb begin
    wx0   = WT_W'(ONE_Q8_8) - WT_W'(fx);
    wx1   = WT_W'(fx);
    wy0   = WT_W'(ONE_Q8_8) - WT_W'(fy);
    wy1   = WT_W'(fy);
    w00   = PW_W'(wx0) * PW_W'(wy0);
    w10   = PW_W'(wx1) * PW_W'(wy0);
    w01   = PW_W'(wx0) * PW_W'(wy1);
    w11   = PW_W'(wx1) * PW_W'(wy1);
    sum   = ACC_W'(w00) * ACC_W'(i00) + ACC_W'(w10) * ACC_W'(i10)
          + ACC_W'(w01) * ACC_W'(i01) + ACC_W'(w11) * ACC_W'(i11);
    rnd   = sum + ACC_W'(ROUND_HALF);
    res   = rnd[ACC_W-1:2*FRAC_BITS];
    pix_c = (res > 9'd255) ? 8'hFF : res[7:0];
  end

endmodule

// File: rtl/dsa_pixel_engine.sv
// Per-pixel responder: raster-tracks output coordinates, fetches a 2x2 source
// neighbourhood, bilinearly interpolates it and writes one output pixel.
module dsa_pixel_engine
  import dsa_pkg::*;
#(
  parameter int unsigned SRC_WIDTH  = 2,
  parameter int unsigned SRC_HEIGHT = 2,
  parameter int unsigned OUT_WIDTH  = 2,
  parameter int unsigned OUT_HEIGHT = 2,
  parameter int unsigned ADDR_W     = (SRC_WIDTH * SRC_HEIGHT > 1) ?
                                      $clog2(SRC_WIDTH * SRC_HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              next_pixel,
  input  logic [15:0]       pixel_index,
  input  logic [15:0]       step_x,
  input  logic [15:0]       step_y,
  output logic              busy,
  output logic              done_pixel,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_we,
  output logic [15:0]       out_addr,
  output logic [7:0]        out_data,
  output logic              overrun,
  output logic              seq_err
);

  pe_state_t         state_q, state_d;
  logic [1:0]        sub_q, sub_d;
  logic [15:0]       exp_q, exp_d, ox_q, ox_d, oy_q, oy_d, cx_q, cx_d, cy_q, cy_d;
  logic [15:0]       x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [7:0]        fx_q, fx_d, fy_q, fy_d;
  logic [7:0]        i00_q, i00_d, i10_q, i10_d, i01_q, i01_d, i11_q, i11_d;
  logic              busy_q, busy_d, done_q, done_d, mem_rd_q, mem_rd_d, out_we_q, out_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       out_addr_q, out_addr_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              overrun_q, overrun_d, seq_err_q, seq_err_d;
  logic [15:0]       base_x, base_y, nx, ny;
  axis_t             ax_c, ay_c;
  logic [7:0]        mac_c;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] lin;
    lin = 32'(y) * SRC_WIDTH + 32'(x);
    return ADDR_W'(lin);
  endfunction

  assign ax_c = axis_calc(cx_q, step_x, SRC_WIDTH - 1);
  assign ay_c = axis_calc(cy_q, step_y, SRC_HEIGHT - 1);

  dsa_bilinear_mac u_mac (
    .fx   (fx_q),
    .fy   (fy_q),
    .i00  (i00_q),
    .i10  (i10_q),
    .i01  (i01_q),
    .i11  (i11_q),
    .pix_c(mac_c)
  );

  always_comb begin
    state_d = state_q;     sub_d = sub_q;       exp_d = exp_q;
    ox_d = ox_q;           oy_d = oy_q;         cx_d = cx_q;         cy_d = cy_q;
    x0_d = x0_q;           x1_d = x1_q;         y0_d = y0_q;         y1_d = y1_q;
    fx_d = fx_q;           fy_d = fy_q;
    i00_d = i00_q;         i10_d = i10_q;       i01_d = i01_q;       i11_d = i11_q;
    mem_rd_d = 1'b0;       mem_addr_d = mem_addr_q;
    out_we_d = 1'b0;       done_d = 1'b0;
    out_addr_d = out_addr_q;  out_data_d = out_data_q;
    overrun_d = overrun_q;    seq_err_d = seq_err_q;
    base_x = ox_q;         base_y = oy_q;       nx = '0;             ny = '0;

    case (state_q)
      S_IDLE, S_WRITE: begin
        state_d = S_IDLE;
        if (next_pixel) begin
          state_d    = S_CALC;
          out_addr_d = pixel_index;
          exp_d      = pixel_index + 16'd1;
          if (pixel_index == 16'd0) begin
            base_x = '0;
            base_y = '0;
          end else if (pixel_index != exp_q) begin
            seq_err_d = 1'b1;
          end
          cx_d = base_x;
          cy_d = base_y;
          nx   = base_x + 16'd1;
          if (32'(nx) >= OUT_WIDTH) begin
            ox_d = '0;
            ny   = base_y + 16'd1;
            oy_d = (32'(ny) >= OUT_HEIGHT) ? 16'd0 : ny;
          end else begin
            ox_d = nx;
            oy_d = base_y;
          end
        end
      end
      S_CALC: begin
        x0_d = ax_c.c0;  x1_d = ax_c.c1;  fx_d = ax_c.f;
        y0_d = ay_c.c0;  y1_d = ay_c.c1;  fy_d = ay_c.f;
        state_d    = S_FETCH;
        sub_d      = 2'd0;
        mem_rd_d   = 1'b1;
        mem_addr_d = addr_of(ax_c.c0, ay_c.c0);
      end
      S_FETCH: begin
        // Data for the read issued last cycle lands now.
        case (sub_q)
          2'd1:    i00_d = mem_rdata;
          2'd2:    i10_d = mem_rdata;
          2'd3:    i01_d = mem_rdata;
          default: ;
        endcase
        if (sub_q == 2'd3) begin
          state_d = S_CAPT;
        end else begin
          sub_d      = sub_q + 2'd1;
          mem_rd_d   = 1'b1;
          mem_addr_d = addr_of(sub_d[0] ? x1_q : x0_q, sub_d[1] ? y1_q : y0_q);
        end
      end
      S_CAPT: begin
        i11_d   = mem_rdata;
        state_d = S_INTERP;
      end
      S_INTERP: begin
        out_data_d = mac_c;
        out_we_d   = 1'b1;
        done_d     = 1'b1;
        state_d    = S_WRITE;
      end
      default: state_d = S_IDLE;
    endcase

    if (next_pixel && state_q != S_IDLE && state_q != S_WRITE) overrun_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  sub_q <= '0;  exp_q <= '0;
      ox_q <= '0;  oy_q <= '0;  cx_q <= '0;  cy_q <= '0;
      x0_q <= '0;  x1_q <= '0;  y0_q <= '0;  y1_q <= '0;  fx_q <= '0;  fy_q <= '0;
      i00_q <= '0;  i10_q <= '0;  i01_q <= '0;  i11_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  mem_rd_q <= 1'b0;  mem_addr_q <= '0;
      out_we_q <= 1'b0;  out_addr_q <= '0;  out_data_q <= '0;
      overrun_q <= 1'b0;  seq_err_q <= 1'b0;
    end else begin
      state_q <= state_d;  sub_q <= sub_d;  exp_q <= exp_d;
      ox_q <= ox_d;  oy_q <= oy_d;  cx_q <= cx_d;  cy_q <= cy_d;
      x0_q <= x0_d;  x1_q <= x1_d;  y0_q <= y0_d;  y1_q <= y1_d;  fx_q <= fx_d;  fy_q <= fy_d;
      i00_q <= i00_d;  i10_q <= i10_d;  i01_q <= i01_d;  i11_q <= i11_d;
      busy_q <= busy_d;  done_q <= done_d;  mem_rd_q <= mem_rd_d;  mem_addr_q <= mem_addr_d;
      out_we_q <= out_we_d;  out_addr_q <= out_addr_d;  out_data_q <= out_data_d;
      overrun_q <= overrun_d;  seq_err_q <= seq_err_d;
    end
  end

  assign busy       = busy_q;
  assign done_pixel = done_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign out_we     = out_we_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign overrun    = overrun_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_dsa_pixel_engine.sv
// Directed bench for dsa_pixel_engine on a 2x2 source / 2x2 output image.
module tb_dsa_pixel_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        next_pixel = 1'b0;
  logic [15:0] pixel_index = '0;
  logic [15:0] step_x = 16'h0100;
  logic [15:0] step_y = 16'h0100;
  logic        busy, done_pixel, mem_rd, out_we, overrun, seq_err;
  logic [1:0]  mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] out_addr;
  logic [7:0]  out_data;
  logic [7:0]  src [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= src[mem_addr];

  dsa_pixel_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_pixel (next_pixel),
    .pixel_index(pixel_index),
    .step_x     (step_x),
    .step_y     (step_y),
    .busy       (busy),
    .done_pixel (done_pixel),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .overrun    (overrun),
    .seq_err    (seq_err)
  );

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    next_pixel = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_src(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic [15:0] step);
    src[0] = a; src[1] = b; src[2] = c; src[3] = d;
    step_x = step; step_y = step;
  endtask

  // Pulse a request; returns at cycle k+1 (one cycle after the accept edge).
  task automatic send(input logic [15:0] idx);
    next_pixel = 1'b1;
    pixel_index = idx;
    @(posedge clk);
    #1 next_pixel = 1'b0;
  endtask

  // Waits for done_pixel and checks latency, read count and written pixel; inj>0 pulses a stray request at that cycle.
  task automatic wait_done(input logic [15:0] idx, input logic [7:0] exp_pix, input int inj);
    int n = 1;
    int rd = 0;
    total++;
    if (done_pixel !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL accept_state idx=%0d: done=%b busy=%b, want done=0 busy=1", idx, done_pixel, busy);
    end
    while (done_pixel !== 1'b1 && n < 20) begin
      if (n == inj) begin
        next_pixel = 1'b1;
        pixel_index = 16'd7;
      end
      @(posedge clk);
      #1 next_pixel = 1'b0;
      n++;
      if (mem_rd === 1'b1) rd++;
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL latency idx=%0d: done at cycle k+%0d, want k+8", idx, n);
    end
    total++;
    if (rd != 4) begin
      bad++;
      $display("FAIL read_count idx=%0d: got %0d reads, want 4", idx, rd);
    end
    total++;
    if (out_we !== 1'b1 || out_addr !== idx) begin
      bad++;
      $display("FAIL write_strobe idx=%0d: we=%b addr=%0d, want we=1 addr=%0d", idx, out_we, out_addr, idx);
    end
    total++;
    if (out_data !== exp_pix) begin
      bad++;
      $display("FAIL pixel idx=%0d: got %0d want %0d", idx, out_data, exp_pix);
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    total++;
    if (busy !== 1'b0 || done_pixel !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 2'd0 ||
        out_we !== 1'b0 || out_addr !== 16'd0 || out_data !== 8'd0 ||
        overrun !== 1'b0 || seq_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b addr=%0d we=%b oaddr=%0d data=%0d ovr=%b seq=%b, want all 0",
               busy, done_pixel, mem_rd, mem_addr, out_we, out_addr, out_data, overrun, seq_err);
    end
  endtask

  task automatic test_identity();
    logic [7:0] e [4];
    e = '{8'd10, 8'd20, 8'd30, 8'd40};
    do_reset(1);
    load_src(8'd10, 8'd20, 8'd30, 8'd40, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      send(16'(i));
      wait_done(16'(i), e[i], 0);
    end
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done_pixel !== 1'b0 || out_we !== 1'b0 || overrun !== 1'b0 || seq_err !== 1'b0) begin
      bad++;
      $display("FAIL identity_idle: busy=%b done=%b we=%b ovr=%b seq=%b, want all 0",
               busy, done_pixel, out_we, overrun, seq_err);
    end
  endtask

  task automatic test_half_step();
    logic [7:0] e [4];
    e = '{8'd0, 8'd50, 8'd100, 8'd139};
    do_reset(1);
    load_src(8'd0, 8'd100, 8'd200, 8'd255, 16'h0080);
    for (int i = 0; i < 4; i++) begin
      send(16'(i));
      wait_done(16'(i), e[i], 0);
    end
  endtask

  task automatic test_edge_clamp();
    logic [7:0] e [4];
    e = '{8'd0, 8'd100, 8'd200, 8'd255};
    do_reset(1);
    load_src(8'd0, 8'd100, 8'd200, 8'd255, 16'h0180);
    for (int i = 0; i < 4; i++) begin
      send(16'(i));
      wait_done(16'(i), e[i], 0);
    end
  endtask

  task automatic test_protocol();
    do_reset(1);
    load_src(8'd0, 8'd100, 8'd200, 8'd255, 16'h0080);
    send(16'd0);
    wait_done(16'd0, 8'd0, 0);
    send(16'd1);
    wait_done(16'd1, 8'd50, 3);
    total++;
    if (overrun !== 1'b1 || seq_err !== 1'b0) begin
      bad++;
      $display("FAIL overrun_flag: ovr=%b seq=%b, want ovr=1 seq=0", overrun, seq_err);
    end
    send(16'd0);
    wait_done(16'd0, 8'd0, 0);
    send(16'd2);
    wait_done(16'd2, 8'd50, 0);
    total++;
    if (seq_err !== 1'b1 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL seq_err_flag: seq=%b ovr=%b, want seq=1 ovr=1", seq_err, overrun);
    end
  endtask

  task automatic test_reset_mid();
    int hits = 0;
    do_reset(1);
    load_src(8'd10, 8'd20, 8'd30, 8'd40, 16'h0100);
    send(16'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    total++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_state: busy=%b rd=%b, want 0 0", busy, mem_rd);
    end
    for (int i = 0; i < 12; i++) begin
      if (out_we === 1'b1 || done_pixel === 1'b1) hits++;
      @(posedge clk);
      #1;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL mid_reset_nowrite: %0d write/done cycles, want 0", hits);
    end
    send(16'd0);
    wait_done(16'd0, 8'd10, 0);
    send(16'd1);
    wait_done(16'd1, 8'd20, 0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_half_step();
    test_edge_clamp();
    test_protocol();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsa_pixel_engine.md
# dsa_pixel_engine

Responder side of the DSA per-pixel handshake. It accepts a `next_pixel` pulse and `pixel_index` from `dsa_control_fsm` and computes one bilinear-interpolated 8-bit output pixel from a source image in synchronous memory. It writes the result to the output buffer and returns a one-cycle `done_pixel` to the control FSM. It sits between `dsa_control_fsm` and the source and destination pixel memories.

## Interface
- `SRC_WIDTH`, default 2: source image width in pixels.
- `SRC_HEIGHT`, default 2: source image height.
- `OUT_WIDTH`, default 2: output image width.
- `OUT_HEIGHT`, default 2: output image height.
- `ADDR_W`, default `$clog2(SRC_WIDTH*SRC_HEIGHT)` (minimum 1): source memory address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `next_pixel`  in  1  one-cycle request pulse from the control FSM.
- `pixel_index`  in  16  linear output index; sampled with `next_pixel`.
- `step_x`, `step_y`  in  16 each  source step per output pixel, unsigned Q8.8. Must be stable while `busy`.
- `busy`  out  1  high from the accept edge through the WRITE cycle.
- `done_pixel`  out  1  one-cycle completion pulse.
- `mem_rd`  out  1  source read strobe.
- `mem_addr`  out  ADDR_W  source address, computed as y*SRC_WIDTH + x.
- `mem_rdata`  in  8  source data, valid one cycle after `mem_rd`.
- `out_we`  out  1  output write strobe.
- `out_addr`  out  16  output address, equal to the latched `pixel_index`.
- `out_data`  out  8  interpolated pixel.
- `overrun`  out  1  sticky; set when `next_pixel` arrives while busy.
- `seq_err`  out  1  sticky; set on a non-sequential index.

## Operation
- States: IDLE, CALC, FETCH (4 sub-cycles 0..3), CAPT, INTERP, WRITE.
- IDLE, with `next_pixel`=1:
  - Latch `pixel_index`.
  - If `pixel_index`==0, clear the ox/oy counters. Otherwise, if `pixel_index` differs from the expected index, set `seq_err`.
  - Go to CALC.
- Coordinates come from the internal ox/oy raster counters. These advance once per accepted pixel: ox wraps at OUT_WIDTH and increments oy; oy wraps at OUT_HEIGHT. The expected index becomes `pixel_index`+1.
- CALC:
  - xs = ox*step_x (32 bit); x0 = xs[31:8]; fx = xs[7:0]. The same rule applies to y.
  - If x0 ≥ SRC_WIDTH-1, then x0 = SRC_WIDTH-1, x1 = x0 and fx = 0. Otherwise x1 = x0+1. The same rule applies to y.
- FETCH: issue reads for I00=(x0,y0), I10=(x1,y0), I01=(x0,y1) and I11=(x1,y1) on 4 consecutive cycles with `mem_rd`=1. Each datum is captured on the cycle after its read; the last one is captured in CAPT.
- INTERP: compute the result and register it into `out_data`.
  - sum = (256-fx)(256-fy)I00 + fx(256-fy)I10 + (256-fx)fy I01 + fx·fy·I11, using a 25-bit accumulator.
  - result = (sum+32768)>>16, saturated to 255.
- WRITE: assert `out_we`=1 and `done_pixel`=1 in the same cycle, then return to IDLE.
- `next_pixel` while busy is ignored and sets `overrun`; the pixel in flight is unaffected.
- `overrun` and `seq_err` clear only on reset.
- Reset, mid-operation included: state goes to IDLE and the pixel in flight is discarded with no write. All outputs, counters, the expected index and the sticky flags go to 0.

## Timing
- Accept at edge k. CALC runs in cycle k+1. FETCH runs in cycles k+2..k+5. CAPT runs in cycle k+6. INTERP runs in cycle k+7. `out_we`, `done_pixel`, `out_addr` and `out_data` are valid in cycle k+8.
- `busy` is high from cycle k+1 through cycle k+8. The earliest next accept is at the edge ending cycle k+8, which gives 8 cycles per pixel.
- `next_pixel` and `done_pixel` can coincide: the edge ending WRITE accepts the new request.
- `mem_rd` is high only during the 4 FETCH cycles. `mem_addr` holds its last value otherwise.

## Structure
- Package `dsa_pkg` holds:
  - the state enum `pe_state_t`;
  - `FRAC_BITS`=8, `ONE_Q8_8`=16'h0100 and `ROUND_HALF`=32768.
- Sub-module `dsa_bilinear_mac` holds the combinational weight/multiply/round/saturate logic, with inputs fx, fy and I00..I11 and an 8-bit output.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → all outputs are 0 and `busy`=0; the first `next_pixel` is accepted normally.
- Identity: source {10,20,30,40}, step 0x0100, 4 requests with indices 0..3 → `out_data` is 10, 20, 30, 40. Each `done_pixel` fires 8 cycles after its accept, and `out_addr` equals the index.
- Half step: source {0,100,200,255}, step 0x0080 on 2x2 output → index 1 gives 50 and index 3 gives 139 (rounding check).
- Edge clamp: step 0x0180 → index 1 gives I(1,0) exactly, with x clamped and fx=0; reads at x1 never exceed SRC_WIDTH-1.
- Protocol: `next_pixel` in FETCH → `overrun`=1 and the pixel in flight is still correct. Indices 0 then 2 → `seq_err`=1.
- Reset mid-FETCH: `rst_n`=0 for 1 cycle → no `out_we` or `done_pixel`, state returns to IDLE, and the following request to index 0 completes correctly.
